// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the mem_access_unit slice.
//   - FNC_* load/store width/sign codes (funct3 field of RV32 loads/stores)
//   - state_e : sequencer state encoding
//   - misaligned_fn : alignment fault detection for the optional trap
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN adds the FAULT state.
package mem_access_unit_pkg;

  // Load codes
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  // Store codes (share encodings with the signed loads)
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ISSUE    = 2'b01,
    ST_WAIT_RSP = 2'b10
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    , ST_FAULT  = 2'b11
`endif
  } state_e;

  // Halfword accesses need a[0]=0, word accesses need a[1:0]=0.
  // Store funct3 values other than SB/SH/SW never fault.
  function automatic logic misaligned_fn(input logic we, input logic [2:0] f3,
                                         input logic [1:0] a);
    logic m;
    m = 1'b0;
    if (we) begin
      case (f3)
        FNC_SH:  m = a[0];
        FNC_SW:  m = |a;
        default: m = 1'b0;
      endcase
    end else begin
      case (f3)
        FNC_LH, FNC_LHU: m = a[0];
        FNC_LW:          m = |a;
        default:         m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory / MMIO bus between mem_access_unit (master) and memory (slave).
//   mem_req_valid/mem_req_ready : request handshake
//   mem_addr                    : word-aligned byte address
//   mem_we                      : byte write mask, 0000 for loads
//   mem_wdata                   : lane-positioned store data
//   mem_rsp_valid/mem_rsp_rdata : load response (no back-pressure)
interface mem_access_unit_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AWIDTH-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DWIDTH-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/mem_access_unit_store_align.sv
// Combinational store lane alignment.
//   we, funct3, addr_lo, data -> mem_we (byte mask), mem_wdata (replicated lanes)
//   misaligned (only with MEM_ACCESS_MISALIGN_TRAP_EN) flags a trapping access.
// Loads produce mask 0000; unknown store codes produce mask 0000 and raw data.
module mem_access_unit_store_align
  import mem_access_unit_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata
);

  logic [3:0] mask_s;

  // Byte mask and data replication by access width; the memory picks lanes via mask.
  always_comb begin
    mask_s    = 4'b0000;
    mem_wdata = data;
    case (funct3)
      FNC_SB: begin
        mask_s    = 4'b0001 << addr_lo;
        mem_wdata = {4{data[7:0]}};
      end
      FNC_SH: begin
        mask_s    = 4'b0011 << {addr_lo[1], 1'b0};
        mem_wdata = {2{data[15:0]}};
      end
      FNC_SW: begin
        mask_s    = 4'b1111;
        mem_wdata = data;
      end
      default: begin
        mask_s    = 4'b0000;
        mem_wdata = data;
      end
    endcase
  end

  // Loads never write.
  always_comb begin
    if (we) begin
      mem_we = mask_s;
    end else begin
      mem_we = 4'b0000;
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misaligned = misaligned_fn(we, funct3, addr_lo);
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute stage and data memory/MMIO.
// Accepts one access in IDLE, issues a word-aligned bus request with byte
// mask and lane-replicated data, and for loads waits for the response, then
// presents raw word + addr_end + funct3 as one consistent triple.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req_*                : CPU request (req_ready high only in IDLE)
//   bus                  : mem_access_unit_if.master memory bus
//   load_out/addr_end/funct3, load_valid : captured load result + 1-cycle pulse
//   store_done           : 1-cycle pulse after the bus accepts a store
//   misalign             : 1-cycle fault pulse, tied 0 unless
//                          MEM_ACCESS_MISALIGN_TRAP_EN is defined
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [DWIDTH-1:0] req_wdata,
  mem_access_unit_if.master bus,
  output logic [DWIDTH-1:0] load_out,
  output logic [1:0]        addr_end,
  output logic [2:0]        funct3,
  output logic              load_valid,
  output logic              store_done,
  output logic              misalign
);

  state_e            state_r, state_s;
  logic              we_r;
  logic [AWIDTH-1:0] addr_r;
  logic [2:0]        op_funct3_r;
  logic [3:0]        mem_we_r;
  logic [DWIDTH-1:0] mem_wdata_r;
  logic [3:0]        align_we_s;
  logic [DWIDTH-1:0] align_wdata_s;
  logic [DWIDTH-1:0] load_out_r;
  logic [1:0]        addr_end_r;
  logic [2:0]        funct3_cap_r;
  logic              load_valid_r;
  logic              store_done_r;
  logic              accept_s;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic              misaligned_s;
`endif

  // Alignment is computed on the incoming request so the bus fields are flopped.
  mem_access_unit_store_align u_store_align (
    .we        (req_we),
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .data      (req_wdata),
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    .misaligned(misaligned_s),
`endif
    .mem_we    (align_we_s),
    .mem_wdata (align_wdata_s)
  );

  assign accept_s = (state_r == ST_IDLE) && req_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; responses outside WAIT_RSP are dropped.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (misaligned_s) begin
            state_s = ST_FAULT;
          end else begin
            state_s = ST_ISSUE;
          end
`else
          state_s = ST_ISSUE;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_req_ready) begin
          state_s = we_r ? ST_IDLE : ST_WAIT_RSP;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT_RSP: begin
        if (bus.mem_rsp_valid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_RSP;
        end
      end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      ST_FAULT: state_s = ST_IDLE;
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // Request latches: hold the bus fields stable through any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r        <= 1'b0;
      addr_r      <= {AWIDTH{1'b0}};
      op_funct3_r <= 3'b000;
      mem_we_r    <= 4'b0000;
      mem_wdata_r <= {DWIDTH{1'b0}};
    end else if (accept_s) begin
      we_r        <= req_we;
      addr_r      <= req_addr;
      op_funct3_r <= req_funct3;
      mem_we_r    <= align_we_s;
      mem_wdata_r <= align_wdata_s;
    end
  end

  // Completion pulses and load result capture; the triple only moves together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_out_r   <= {DWIDTH{1'b0}};
      addr_end_r   <= 2'b00;
      funct3_cap_r <= 3'b000;
      load_valid_r <= 1'b0;
      store_done_r <= 1'b0;
    end else begin
      load_valid_r <= (state_r == ST_WAIT_RSP) && bus.mem_rsp_valid;
      store_done_r <= (state_r == ST_ISSUE) && bus.mem_req_ready && we_r;
      if ((state_r == ST_WAIT_RSP) && bus.mem_rsp_valid) begin
        load_out_r   <= bus.mem_rsp_rdata;
        addr_end_r   <= addr_r[1:0];
        funct3_cap_r <= op_funct3_r;
      end
    end
  end

  // Handshake outputs decode straight from the state flop, so reset drops them at once.
  assign req_ready         = (state_r == ST_IDLE);
  assign bus.mem_req_valid = (state_r == ST_ISSUE);
  assign bus.mem_addr      = {addr_r[AWIDTH-1:2], 2'b00};
  assign bus.mem_we        = mem_we_r;
  assign bus.mem_wdata     = mem_wdata_r;

  assign load_out   = load_out_r;
  assign addr_end   = addr_end_r;
  assign funct3     = funct3_cap_r;
  assign load_valid = load_valid_r;
  assign store_done = store_done_r;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misalign = (state_r == ST_FAULT);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a table of single accesses on a
// zero-wait bus, plus hand-written multi-cycle sequences (response waits,
// bus stall, reset mid-access, back-to-back ops, optional misalign trap).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic [31:0] load_out;
  logic [1:0]  addr_end;
  logic [2:0]  funct3;
  logic        load_valid;
  logic        store_done;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mem_access_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_funct3(req_funct3),
    .req_wdata (req_wdata),
    .bus       (bus),
    .load_out  (load_out),
    .addr_end  (addr_end),
    .funct3    (funct3),
    .load_valid(load_valid),
    .store_done(store_done),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic        chk_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rsp, logic [31:0] exp_addr, logic [3:0] exp_we,
                              logic [31:0] exp_wdata, logic chk_wdata);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rsp = rsp;
    v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_wdata = exp_wdata; v.chk_wdata = chk_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happen 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access on a bus that accepts at once and answers after `waits` idle cycles.
  task automatic run_access(input vec_t v, input int waits, input string tag);
    chk({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_funct3 = v.f3; req_wdata = v.wdata;
    step();
    req_valid = 1'b0;
    chk({tag, " mem_req_valid"}, {31'd0, bus.mem_req_valid}, 32'd1);
    chk({tag, " req_ready busy"}, {31'd0, req_ready}, 32'd0);
    chk({tag, " mem_addr"}, bus.mem_addr, v.exp_addr);
    chk({tag, " mem_we"}, {28'd0, bus.mem_we}, {28'd0, v.exp_we});
    if (v.chk_wdata) chk({tag, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk({tag, " misalign"}, {31'd0, misalign}, 32'd0);
    if (v.we) begin
      chk({tag, " store_done"}, {31'd0, store_done}, 32'd1);
      chk({tag, " load_valid on store"}, {31'd0, load_valid}, 32'd0);
      step();
      chk({tag, " store_done pulse"}, {31'd0, store_done}, 32'd0);
    end else begin
      chk({tag, " mem_req_valid wait"}, {31'd0, bus.mem_req_valid}, 32'd0);
      chk({tag, " load_valid early"}, {31'd0, load_valid}, 32'd0);
      for (int i = 0; i < waits; i++) begin
        step();
        chk({tag, " load_valid during wait"}, {31'd0, load_valid}, 32'd0);
      end
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = v.rsp;
      step();
      bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'h0000_0000;
      chk({tag, " load_valid"}, {31'd0, load_valid}, 32'd1);
      chk({tag, " load_out"}, load_out, v.rsp);
      chk({tag, " addr_end"}, {30'd0, addr_end}, {30'd0, v.addr[1:0]});
      chk({tag, " funct3"}, {29'd0, funct3}, {29'd0, v.f3});
      chk({tag, " store_done on load"}, {31'd0, store_done}, 32'd0);
      step();
      chk({tag, " load_valid pulse"}, {31'd0, load_valid}, 32'd0);
      chk({tag, " load_out hold"}, load_out, v.rsp);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_funct3 = 3'b000;
    req_wdata = 32'h0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;

    vecs.push_back(mk(1'b1, FNC_SB, 32'h0000_1003, 32'h0000_00A5, 32'h0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b1));
    vecs.push_back(mk(1'b1, FNC_SB, 32'h0000_1000, 32'h1234_5678, 32'h0, 32'h0000_1000, 4'b0001, 32'h7878_7878, 1'b1));
    vecs.push_back(mk(1'b1, FNC_SH, 32'h0000_1002, 32'hDEAD_BEEF, 32'h0, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 1'b1));
    vecs.push_back(mk(1'b1, FNC_SH, 32'h0000_1000, 32'hCAFE_1234, 32'h0, 32'h0000_1000, 4'b0011, 32'h1234_1234, 1'b1));
    vecs.push_back(mk(1'b1, FNC_SW, 32'h0000_2004, 32'h0123_4567, 32'h0, 32'h0000_2004, 4'b1111, 32'h0123_4567, 1'b1));
    vecs.push_back(mk(1'b1, 3'b011, 32'h0000_0011, 32'hFFFF_0000, 32'h0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, FNC_LW, 32'h0000_4000, 32'h0, 32'h1122_3344, 32'h0000_4000, 4'b0000, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, FNC_LBU, 32'h0000_4003, 32'h0, 32'hAABB_CCDD, 32'h0000_4000, 4'b0000, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, FNC_LHU, 32'h0000_5006, 32'h0, 32'h5A5A_0F0F, 32'h0000_5004, 4'b0000, 32'h0, 1'b0));
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
    vecs.push_back(mk(1'b1, FNC_SH, 32'h0000_1001, 32'h0000_ABCD, 32'h0, 32'h0000_1000, 4'b0011, 32'hABCD_ABCD, 1'b1));
    vecs.push_back(mk(1'b1, FNC_SW, 32'h0000_1003, 32'h8765_4321, 32'h0, 32'h0000_1000, 4'b1111, 32'h8765_4321, 1'b1));
    vecs.push_back(mk(1'b0, FNC_LW, 32'h0000_3001, 32'h0, 32'hFEED_F00D, 32'h0000_3000, 4'b0000, 32'h0, 1'b0));
`endif

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("reset load_out", load_out, 32'd0);
    chk("reset addr_end", {30'd0, addr_end}, 32'd0);
    chk("reset funct3", {29'd0, funct3}, 32'd0);
    chk("reset pulses", {29'd0, load_valid, store_done, misalign}, 32'd0);

    // Table vectors on a zero-wait bus
    for (int i = 0; i < vecs.size(); i++) begin
      run_access(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // LH with two response wait cycles
    v = mk(1'b0, FNC_LH, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 32'h0000_2000, 4'b0000, 32'h0, 1'b0);
    run_access(v, 2, "lh_wait2");

    // Bus stall: request fields hold and a second request is ignored
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0500; req_funct3 = FNC_SW;
    req_wdata = 32'h5555_AAAA;
    step();
    req_addr = 32'h0000_0903; req_funct3 = FNC_SB; req_wdata = 32'h0000_0011;
    for (int i = 0; i < 5; i++) begin
      chk("stall mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      chk("stall mem_addr", bus.mem_addr, 32'h0000_0500);
      chk("stall mem_we", {28'd0, bus.mem_we}, 32'h0000_000F);
      chk("stall mem_wdata", bus.mem_wdata, 32'h5555_AAAA);
      chk("stall req_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("stall store_done", {31'd0, store_done}, 32'd1);
    step();
    chk("stall no replay", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("stall no second done", {31'd0, store_done}, 32'd0);

    // Asynchronous reset during ISSUE drops mem_req_valid before any clock edge
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6000; req_funct3 = FNC_LW;
    step();
    req_valid = 1'b0;
    chk("async pre mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async mem_req_valid drop", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("async req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    step();

    // Reset in WAIT_RSP: late response is dropped, outputs stay cleared
    v = mk(1'b0, FNC_LW, 32'h0000_6004, 32'h0, 32'h0BAD_0BAD, 32'h0000_6004, 4'b0000, 32'h0, 1'b0);
    run_access(v, 0, "pre_rst_load");
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6008; req_funct3 = FNC_LHU;
    step();
    req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("rst_wait load_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_wait load_out", load_out, 32'd0);
    chk("rst_wait addr_end", {30'd0, addr_end}, 32'd0);
    chk("rst_wait funct3", {29'd0, funct3}, 32'd0);
    step();
    chk("rst_wait load_valid late", {31'd0, load_valid}, 32'd0);
    v = mk(1'b0, FNC_LB, 32'h0000_7001, 32'h0, 32'h0000_8000, 32'h0000_7000, 4'b0000, 32'h0, 1'b0);
    run_access(v, 0, "post_rst_load");

    // Back-to-back SW then LBU: LBU issues the cycle after store_done
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0100; req_funct3 = FNC_SW;
    req_wdata = 32'hCAFE_F00D;
    step();
    req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("b2b store_done", {31'd0, store_done}, 32'd1);
    chk("b2b req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0202; req_funct3 = FNC_LBU;
    step();
    req_valid = 1'b0;
    chk("b2b second issue", {31'd0, bus.mem_req_valid}, 32'd1);
    chk("b2b second addr", bus.mem_addr, 32'h0000_0200);
    chk("b2b second mask", {28'd0, bus.mem_we}, 32'd0);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h0102_0304;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("b2b load_valid", {31'd0, load_valid}, 32'd1);
    chk("b2b load_out", load_out, 32'h0102_0304);
    chk("b2b addr_end", {30'd0, addr_end}, 32'd2);
    chk("b2b funct3", {29'd0, funct3}, {29'd0, FNC_LBU});
    step();

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    // Misaligned LW traps without touching the bus
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_3001; req_funct3 = FNC_LW;
    step();
    req_valid = 1'b0;
    chk("trap misalign", {31'd0, misalign}, 32'd1);
    chk("trap no bus", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("trap req_ready", {31'd0, req_ready}, 32'd0);
    step();
    chk("trap misalign pulse", {31'd0, misalign}, 32'd0);
    chk("trap back idle", {31'd0, req_ready}, 32'd1);
    chk("trap no bus after", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("trap no completion", {30'd0, load_valid, store_done}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
